// File: rtl/mdu_pkg.sv
// Shared types and MDU op-code constants for the multiply/divide arbiter.
package mdu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } arb_state_e;

    typedef logic req_id_t;

    localparam int unsigned MT_W = 4;

    localparam logic [MT_W-1:0] mtMultiply         = 4'd0;
    localparam logic [MT_W-1:0] mtMultiplyUnsigned = 4'd1;
    localparam logic [MT_W-1:0] mtDivide           = 4'd2;
    localparam logic [MT_W-1:0] mtDivideUnsigned   = 4'd3;
    localparam logic [MT_W-1:0] mtMADD             = 4'd4;
    localparam logic [MT_W-1:0] mtMADDU            = 4'd5;
    localparam logic [MT_W-1:0] mtMSUB             = 4'd6;
    localparam logic [MT_W-1:0] mtMSUBU            = 4'd7;
    localparam logic [MT_W-1:0] mtSetHI            = 4'd8;
    localparam logic [MT_W-1:0] mtSetLO            = 4'd9;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the one not granted last.
module rr_arb2
    import mdu_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | last);
    assign grant[1] = valid[1] & (~valid[0] | ~last);

endmodule

// File: rtl/mdu_arbiter.sv
// Shares one multiply/divide unit between two pipe slots with per-slot kill.
// Optional watchdog on the WAIT state: define MDU_ARB_WATCHDOG_EN.
module mdu_arbiter
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CTRL_W  = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [CTRL_W-1:0] r0_ctrl,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic              r0_kill,
    output logic              r0_done,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [CTRL_W-1:0] r1_ctrl,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic              r1_kill,
    output logic              r1_done,
    output logic [DATA_W-1:0] done_hi,
    output logic [DATA_W-1:0] done_lo,
    output logic              mdu_start,
    output logic [CTRL_W-1:0] mdu_ctrl,
    output logic [DATA_W-1:0] mdu_a,
    output logic [DATA_W-1:0] mdu_b,
    input  logic              mdu_busy,
    input  logic [DATA_W-1:0] mdu_hi,
    input  logic [DATA_W-1:0] mdu_lo,
    output logic              arb_busy,
    output logic              wdt_err
);

    arb_state_e        state_q, state_d;
    req_id_t           owner_q, owner_d;
    req_id_t           last_q, last_d;
    logic              killed_q, killed_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;

`ifdef MDU_ARB_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_err_q, wdt_err_d;
`endif

    logic [1:0] grant;
    logic       accept0, accept1;
    logic       owner_kill;
    logic       is_set_op;
    logic       done_act;

    rr_arb2 u_rr_arb2 (
        .valid ({r1_valid, r0_valid}),
        .last  (last_q),
        .grant (grant)
    );

    assign r0_ready   = (state_q == ST_IDLE) & grant[0] & ~r0_kill;
    assign r1_ready   = (state_q == ST_IDLE) & grant[1] & ~r1_kill;
    assign accept0    = r0_ready & r0_valid;
    assign accept1    = r1_ready & r1_valid;
    assign owner_kill = owner_q ? r1_kill : r0_kill;
    assign is_set_op  = (ctrl_q == CTRL_W'(mtSetHI)) || (ctrl_q == CTRL_W'(mtSetLO));

    // A kill landing in the DONE cycle itself still suppresses the pulse.
    assign done_act  = (state_q == ST_DONE) & ~killed_q & ~owner_kill;
    assign r0_done   = done_act & ~owner_q;
    assign r1_done   = done_act & owner_q;
    assign done_hi   = done_act ? mdu_hi : '0;
    assign done_lo   = done_act ? mdu_lo : '0;

    assign mdu_start = (state_q == ST_ISSUE);
    assign mdu_ctrl  = ctrl_q;
    assign mdu_a     = a_q;
    assign mdu_b     = b_q;
    assign arb_busy  = (state_q != ST_IDLE);

    // Next-state and operand capture.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        killed_d = killed_q;
        ctrl_d   = ctrl_q;
        a_d      = a_q;
        b_d      = b_q;
`ifdef MDU_ARB_WATCHDOG_EN
        wdt_cnt_d = wdt_cnt_q;
        wdt_err_d = wdt_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept0 || accept1) begin
                    owner_d = accept1;
                    last_d  = accept1;
                    ctrl_d  = accept1 ? r1_ctrl : r0_ctrl;
                    a_d     = accept1 ? r1_a : r0_a;
                    b_d     = accept1 ? r1_b : r0_b;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (owner_kill) killed_d = 1'b1;
                state_d = is_set_op ? ST_DONE : ST_WAIT;
`ifdef MDU_ARB_WATCHDOG_EN
                wdt_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (owner_kill) killed_d = 1'b1;
                if (!mdu_busy) state_d = ST_DONE;
`ifdef MDU_ARB_WATCHDOG_EN
                wdt_cnt_d = wdt_cnt_q + CNT_W'(1);
                if (mdu_busy && (wdt_cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    wdt_err_d = 1'b1;
                    killed_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
`endif
            end
            ST_DONE: begin
                killed_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            killed_q <= 1'b0;
            ctrl_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
`ifdef MDU_ARB_WATCHDOG_EN
            wdt_cnt_q <= '0;
            wdt_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            killed_q <= killed_d;
            ctrl_q   <= ctrl_d;
            a_q      <= a_d;
            b_q      <= b_d;
`ifdef MDU_ARB_WATCHDOG_EN
            wdt_cnt_q <= wdt_cnt_d;
            wdt_err_q <= wdt_err_d;
`endif
        end
    end

`ifdef MDU_ARB_WATCHDOG_EN
    assign wdt_err = wdt_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign wdt_err = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed bench for mdu_arbiter with a behavioural multiply/divide unit model.
module tb_mdu_arbiter;
    import mdu_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned TIMEOUT = 16;

    logic              clk;
    logic              reset;
    logic              r0_valid, r1_valid, r0_ready, r1_ready;
    logic [CTRL_W-1:0] r0_ctrl, r1_ctrl;
    logic [DATA_W-1:0] r0_a, r0_b, r1_a, r1_b;
    logic              r0_kill, r1_kill, r0_done, r1_done;
    logic [DATA_W-1:0] done_hi, done_lo;
    logic              mdu_start;
    logic [CTRL_W-1:0] mdu_ctrl;
    logic [DATA_W-1:0] mdu_a, mdu_b;
    logic              arb_busy, wdt_err;

    logic              u_busy;
    logic [DATA_W-1:0] u_hi, u_lo;
    logic [CTRL_W-1:0] u_ctrl;
    logic [DATA_W-1:0] u_a, u_b;
    int unsigned       u_cnt;
    int unsigned       busy_len;
    bit                hang;

    int checks = 0;
    int errors = 0;

    mdu_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_ctrl(r0_ctrl), .r0_a(r0_a), .r0_b(r0_b),
        .r0_kill(r0_kill), .r0_done(r0_done),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_ctrl(r1_ctrl), .r1_a(r1_a), .r1_b(r1_b),
        .r1_kill(r1_kill), .r1_done(r1_done),
        .done_hi(done_hi), .done_lo(done_lo),
        .mdu_start(mdu_start), .mdu_ctrl(mdu_ctrl), .mdu_a(mdu_a), .mdu_b(mdu_b),
        .mdu_busy(u_busy), .mdu_hi(u_hi), .mdu_lo(u_lo),
        .arb_busy(arb_busy), .wdt_err(wdt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mdu_result(input logic [CTRL_W-1:0] c, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (c)
            mtMultiply:         return sa * sb;
            mtMultiplyUnsigned: return ua * ub;
            mtMADD:             return acc + sa * sb;
            mtMADDU:            return acc + ua * ub;
            mtMSUB:             return acc - sa * sb;
            mtMSUBU:            return acc - ua * ub;
            mtDivide:           return (b == 0) ? acc : {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            mtDivideUnsigned:   return (b == 0) ? acc : {a % b, a / b};
            default:            return acc;
        endcase
    endfunction

    // Unit model: busy rises the cycle after start and stays high busy_len cycles.
    always @(posedge clk) begin
        if (reset) begin
            u_busy <= 1'b0;
            u_cnt  <= 0;
            u_hi   <= '0;
            u_lo   <= '0;
        end else if (mdu_start) begin
            if (mdu_ctrl == mtSetHI) u_hi <= mdu_a;
            else if (mdu_ctrl == mtSetLO) u_lo <= mdu_a;
            else begin
                u_busy <= 1'b1;
                u_cnt  <= busy_len;
                u_ctrl <= mdu_ctrl;
                u_a    <= mdu_a;
                u_b    <= mdu_b;
            end
        end else if (u_busy && !hang) begin
            if (u_cnt <= 1) begin
                u_busy       <= 1'b0;
                {u_hi, u_lo} <= mdu_result(u_ctrl, u_a, u_b, {u_hi, u_lo});
            end else begin
                u_cnt <= u_cnt - 1;
            end
        end
    end

    typedef struct {
        logic        rid;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned blen;
        bit          other_kill;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from the current (IDLE) cycle and checks its completion.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int starts;
        int k;
        busy_len = v.blen;
        if (v.rid) begin
            r1_valid = 1'b1; r1_ctrl = v.ctrl; r1_a = v.a; r1_b = v.b;
        end else begin
            r0_valid = 1'b1; r0_ctrl = v.ctrl; r0_a = v.a; r0_b = v.b;
        end
        #1;
        k = 0;
        while (!(v.rid ? r1_ready : r0_ready) && k < 8) begin
            cyc(); #1; k++;
        end
        check($sformatf("v%0d_ready", idx), 64'(v.rid ? r1_ready : r0_ready), 64'(1));
        cyc();
        r0_valid = 1'b0; r1_valid = 1'b0;
        if (v.other_kill) begin
            if (v.rid) r0_kill = 1'b1; else r1_kill = 1'b1;
        end
        #1;
        lat = 1;
        starts = int'(mdu_start);
        check($sformatf("v%0d_issue_ctrl", idx), 64'(mdu_ctrl), 64'(v.ctrl));
        check($sformatf("v%0d_issue_a", idx), 64'(mdu_a), 64'(v.a));
        while (!(r0_done || r1_done) && lat < 200) begin
            cyc();
            r0_kill = 1'b0; r1_kill = 1'b0;
            #1;
            lat++;
            starts += int'(mdu_start);
        end
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("v%0d_done_owner", idx), 64'({r1_done, r0_done}), 64'(v.rid ? 2'b10 : 2'b01));
        check($sformatf("v%0d_hi", idx), 64'(done_hi), 64'(v.exp_hi));
        check($sformatf("v%0d_lo", idx), 64'(done_lo), 64'(v.exp_lo));
        check($sformatf("v%0d_hold_b", idx), 64'(mdu_b), 64'(v.b));
        check($sformatf("v%0d_starts", idx), 64'(starts), 64'(1));
        cyc(); #1;
        check($sformatf("v%0d_after_done", idx),
              64'({r1_done, r0_done, arb_busy}) | 64'(done_hi | done_lo), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang, expected completion");
        $fatal(1, "simulation did not terminate");
    end

    initial begin : stim
        int lat;
        logic seen;
        vec_t kv;

        vecs[0] = '{1'b0, mtMultiply,         32'd7,          32'd6,    9, 1'b0, 32'h0,        32'd42,       12};
        vecs[1] = '{1'b1, mtDivide,           32'd100,        32'd7,    5, 1'b1, 32'd2,        32'd14,        8};
        vecs[2] = '{1'b1, mtDivideUnsigned,   32'd55,         32'd0,    3, 1'b0, 32'd2,        32'd14,        6};
        vecs[3] = '{1'b0, mtMultiply,         32'hFFFF_FFFD,  32'd5,    2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
        vecs[4] = '{1'b1, mtMultiplyUnsigned, 32'hFFFF_FFFF,  32'd2,    1, 1'b0, 32'd1,        32'hFFFF_FFFE, 4};
        vecs[5] = '{1'b0, mtSetLO,            32'hA5,         32'd0,    1, 1'b0, 32'd1,        32'hA5,        2};
        vecs[6] = '{1'b1, mtSetHI,            32'h5A,         32'd0,    1, 1'b0, 32'h5A,       32'hA5,        2};
        vecs[7] = '{1'b0, mtMADD,             32'd3,          32'd4,    2, 1'b0, 32'h5A,       32'hB1,        5};
        vecs[8] = '{1'b0, mtMSUB,             32'd1,          32'hB1,   1, 1'b0, 32'h5A,       32'h0,         4};

        reset = 1'b1; hang = 1'b0; busy_len = 1;
        r0_valid = 0; r1_valid = 0; r0_kill = 0; r1_kill = 0;
        r0_ctrl = '0; r1_ctrl = '0; r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
        repeat (3) cyc();
        check("reset_ctl", 64'({arb_busy, mdu_start, r0_done, r1_done, r0_ready, r1_ready, wdt_err}), 64'(0));
        check("reset_data", 64'(done_hi | done_lo | mdu_a | mdu_b) | 64'(mdu_ctrl), 64'(0));
        reset = 1'b0;

        // Tie after reset goes to r0, then r1 while r0 stays valid.
        cyc();
        r0_valid = 1; r1_valid = 1; r0_ctrl = mtSetHI; r1_ctrl = mtSetHI; r0_a = 32'h11; r1_a = 32'h22;
        #1;
        check("tie_first_grant", 64'({r1_ready, r0_ready}), 64'(2'b01));
        cyc(); #1;
        check("issue_start", 64'(mdu_start), 64'(1));
        check("issue_no_ready", 64'({r1_ready, r0_ready}), 64'(0));
        cyc(); #1;
        check("tie_done0", 64'({r1_done, r0_done}), 64'(2'b01));
        check("tie_hi0", 64'(done_hi), 64'(32'h11));
        check("done_no_ready", 64'({r1_ready, r0_ready}), 64'(0));
        cyc(); #1;
        check("tie_second_grant", 64'({r1_ready, r0_ready}), 64'(2'b10));
        cyc();
        r0_valid = 0; r1_valid = 0;
        #1;
        cyc(); #1;
        check("tie_done1", 64'({r1_done, r0_done}), 64'(2'b10));
        check("tie_hi1", 64'(done_hi), 64'(32'h22));
        cyc(); #1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Owner kill two cycles into WAIT: no done, unit still runs out.
        busy_len = 6;
        r0_valid = 1; r0_ctrl = mtMultiply; r0_a = 32'd7; r0_b = 32'd6;
        #1;
        check("kill_ready", 64'(r0_ready), 64'(1));
        cyc(); r0_valid = 0; #1;
        seen = 1'b0;
        cyc(); #1;
        seen |= r0_done | r1_done;
        cyc();
        r0_kill = 1;
        #1;
        seen |= r0_done | r1_done;
        cyc();
        r0_kill = 0;
        #1;
        lat = 4;
        seen |= r0_done | r1_done;
        while (arb_busy && lat < 100) begin
            cyc(); #1; lat++;
            seen |= r0_done | r1_done;
        end
        check("kill_idle_latency", 64'(lat), 64'(10));
        check("kill_no_done", 64'(seen), 64'(0));
        kv = '{1'b1, mtSetLO, 32'd7, 32'd0, 1, 1'b0, 32'd0, 32'd7, 2};
        run_vec(kv, 9);

        // Reset during WAIT; afterwards the tie must go to r0 again.
        busy_len = 20;
        r0_valid = 1; r0_ctrl = mtMultiply; r0_a = 32'd3; r0_b = 32'd3;
        #1;
        check("rst_req_ready", 64'(r0_ready), 64'(1));
        cyc(); r0_valid = 0; #1;
        cyc(); cyc(); #1;
        check("rst_pre_busy", 64'(arb_busy), 64'(1));
        reset = 1;
        cyc(); #1;
        check("rst_mid_ctl", 64'({arb_busy, mdu_start, r0_done, r1_done}), 64'(0));
        check("rst_mid_data", 64'(done_hi | done_lo), 64'(0));
        reset = 0;
        r0_valid = 1; r1_valid = 1; r0_ctrl = mtSetHI; r1_ctrl = mtSetHI; r0_a = 32'h33; r1_a = 32'h44;
        #1;
        check("rst_tie_grant", 64'({r1_ready, r0_ready}), 64'(2'b01));
        cyc(); r0_valid = 0; r1_valid = 0; #1;
        cyc(); #1;
        check("rst_tie_done", 64'({r1_done, r0_done}), 64'(2'b01));
        check("rst_tie_hi", 64'(done_hi), 64'(32'h33));
        cyc(); #1;

`ifdef MDU_ARB_WATCHDOG_EN
        // Unit hangs: watchdog forces IDLE after TIMEOUT WAIT cycles.
        hang = 1'b1; busy_len = 5;
        r1_valid = 1; r1_ctrl = mtMultiply; r1_a = 32'd2; r1_b = 32'd2;
        #1;
        check("wdt_ready", 64'(r1_ready), 64'(1));
        cyc(); r1_valid = 0; #1;
        lat = 1; seen = 1'b0;
        while (arb_busy && lat < 100) begin
            cyc(); #1; lat++;
            seen |= r0_done | r1_done;
        end
        check("wdt_idle_latency", 64'(lat), 64'(18));
        check("wdt_no_done", 64'(seen), 64'(0));
        check("wdt_set", 64'(wdt_err), 64'(1));
        repeat (3) cyc();
        check("wdt_sticky", 64'(wdt_err), 64'(1));
        reset = 1;
        cyc();
        reset = 0; hang = 1'b0;
        #1;
        check("wdt_cleared", 64'(wdt_err), 64'(0));
`else
        check("wdt_tied_low", 64'(wdt_err), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_arbiter.md
Name: mdu_arbiter

Overview:
- Shares the single multiply/divide unit and its HI/LO registers between two requesters (pipe slot 0 and pipe slot 1).
- Accepts one operation at a time over a valid/ready handshake and drives the unit's start/ctrl/A/B pins.
- Tracks the unit's busy flag to completion, then returns HI/LO to the owning requester with a done pulse.
- Supports per-requester kill (flush) of an in-flight operation.

Parameters:
- DATA_W, 32, operand and HI/LO width
- CTRL_W, 4, width of the MDU op code (mt* encodings)
- TIMEOUT, 64, watchdog limit in WAIT cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- r0_valid / r1_valid  in  1  request present
- r0_ready / r1_ready  out  1  arbiter accepts this cycle
- r0_ctrl / r1_ctrl  in  CTRL_W  MDU op code
- r0_a, r0_b / r1_a, r1_b  in  DATA_W  operands
- r0_kill / r1_kill  in  1  flush; cancels that requester's pending or in-flight op
- r0_done / r1_done  out  1  one-cycle completion pulse
- done_hi, done_lo  out  DATA_W  HI/LO snapshot, valid while any rX_done=1
- mdu_start  out  1  start pulse to the unit
- mdu_ctrl  out  CTRL_W  registered op code
- mdu_a, mdu_b  out  DATA_W  registered operands
- mdu_busy  in  1  unit busy; registered, rises the cycle after start
- mdu_hi, mdu_lo  in  DATA_W  unit HI/LO registers
- arb_busy  out  1  state != IDLE
- wdt_err  out  1  sticky watchdog error (optional feature only)

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_grant=1, so r0 wins the first tie; killed=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Winner = sole valid requester; on a tie, the requester not granted last.
  - rX_ready=1 only for the winner, gated by ~rX_kill.
  - On handshake: latch ctrl/a/b and owner, update last_grant, go to ISSUE.
  - valid&kill in the same cycle: no accept.
- ISSUE:
  - mdu_start=1 for exactly one cycle.
  - mdu_ctrl/a/b hold the latched values from ISSUE through DONE.
  - If ctrl is mtSetHI or mtSetLO, go to DONE; otherwise go to WAIT.
- WAIT: stay while mdu_busy=1; go to DONE in the cycle after mdu_busy is sampled 0.
- DONE:
  - owner's rX_done=1 unless killed; done_hi=mdu_hi, done_lo=mdu_lo.
  - Clear killed; go to IDLE. No request is accepted in DONE.
- Throughput: at most one op per 3 cycles (set ops). Set-op latency: handshake cycle N, done at N+2.
- Kill of the owner in ISSUE/WAIT/DONE:
  - Sets killed, which suppresses done in the same or later DONE cycle.
  - The unit still runs to completion and is never aborted.
  - Kill from the non-owner is ignored.
- Divide by zero: the unit leaves HI/LO unchanged; the arbiter completes normally and done returns the unchanged HI/LO.
- Both requesters stay valid: grants alternate r0, r1, r0, ...
- Reset mid-operation: immediate return to IDLE with mdu_start=0. The unit shares the reset, so no stale busy remains.
- done_hi/done_lo are 0 when no done pulse is active.

Optional Feature:
- Macro: MDU_ARB_WATCHDOG_EN.
- With the macro:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT sets wdt_err (sticky until reset) and forces IDLE with no done pulse.
- Without the macro: no counter; wdt_err is tied 0.

Decomposition:
- Package mdu_pkg holds:
  - the FSM state enum
  - the requester-id type (1 bit)
  - the MDU op-code constants mtSetHI, mtSetLO, mtMultiply, mtMultiplyUnsigned, mtDivide, mtDivideUnsigned, mtMADD, mtMADDU, mtMSUB (same values as the shared constants include)
- Sub-module rr_arb2: two-way round-robin picker (inputs valid[1:0], last; outputs grant[1:0]).

Test Plan:
- r0 mtMultiply, A=7, B=6; unit model busy for 9 cycles → r0_done exactly one pulse, one cycle after busy falls; done_lo=42, done_hi=0; r1_done never asserts.
- r0 and r1 valid in the same cycle after reset, both mtSetHI with A=0x11 and A=0x22 → r0 granted first, done_hi=0x11; then r1, done_hi=0x22; each done 2 cycles after its handshake.
- r1 mtDivide, A=100, B=7 → r1_done with done_lo=14, done_hi=2. Then r1 mtDivideUnsigned, B=0 → done returns unchanged HI=2, LO=14.
- r0 mtMultiply, r0_kill pulsed 2 cycles into WAIT → no r0_done; arb_busy stays 1 until busy falls, then IDLE; the next r1 request is accepted in the following cycle.
- reset asserted during WAIT → next cycle state=IDLE, mdu_start=0, all done=0, arb_busy=0; the next tie grants r0.
- With MDU_ARB_WATCHDOG_EN and TIMEOUT=16, unit model holds busy=1 forever → wdt_err=1 after 16 WAIT cycles, no done, arb_busy=0; wdt_err stays 1 until reset.
